// File: rtl/dfp_mem_responder.sv
// Memory stand-in for the cache's downstream port: an on-chip line array behind a
// programmable-latency responder that services one line read or write at a time.
module dfp_mem_responder #(
   parameter int DEPTH_LINES   = 256,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  dfp_addr,
   input  logic         dfp_read,
   input  logic         dfp_write,
   input  logic [255:0] dfp_wdata,
   output logic [255:0] dfp_rdata,
   output logic         dfp_resp,
   output logic         busy,
   output logic         err
);

   localparam int IDX_W = $clog2(DEPTH_LINES);
   localparam logic [15:0] RD_LAT = 16'(READ_LATENCY);
   localparam logic [15:0] WR_LAT = 16'(WRITE_LATENCY);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN} state_t;

   state_t             r_state;
   logic [15:0]        r_cnt;
   logic               r_is_write;
   logic               r_resp;
   logic               r_busy;
   logic               r_err;
   logic [255:0]       r_rdata;
   logic [IDX_W-1:0]   r_idx;
   logic [255:0]       r_wdata;
   logic [255:0]       r_mem [DEPTH_LINES];

   logic [IDX_W-1:0]   w_idx;
   logic               w_rd_only;
   logic               w_wr_only;
   logic               w_accept;
   logic               w_misalign;
   logic [15:0]        w_lat;
   logic               w_unused_addr;

   // Offset bits and address bits above the index are deliberately dropped.
   assign w_idx         = dfp_addr[5 +: IDX_W];
   assign w_unused_addr = ^dfp_addr;
   assign w_rd_only     = dfp_read & ~dfp_write;
   assign w_wr_only     = dfp_write & ~dfp_read;
   assign w_accept      = (r_state == S_IDLE) & (w_rd_only | w_wr_only);
   assign w_misalign    = |dfp_addr[4:0];
   assign w_lat         = dfp_write ? WR_LAT : RD_LAT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_is_write <= 1'b0;
         r_resp     <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_resp <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (dfp_read && dfp_write) begin
                  r_err <= 1'b1;
               end else if (w_accept) begin
                  r_is_write <= dfp_write;
                  r_busy     <= 1'b1;
                  if (w_misalign) r_err <= 1'b1;
                  if (w_lat == 16'd1) begin
                     r_state <= S_RESP;
                     r_resp  <= 1'b1;
                     if (!dfp_write) r_rdata <= r_mem[w_idx];
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= w_lat - 16'd1;
                  end
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 16'd1;
               if (r_cnt == 16'd1) begin
                  r_state <= S_RESP;
                  r_resp  <= 1'b1;
                  if (!r_is_write) r_rdata <= r_mem[r_idx];
               end
            end
            S_RESP:  r_state <= S_DRAIN;
            S_DRAIN: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write commits on the edge leaving RESP; a reset before then drops it.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_idx   <= w_idx;
         r_wdata <= dfp_wdata;
      end
      if (r_state == S_RESP && r_is_write) r_mem[r_idx] <= r_wdata;
   end

   assign dfp_rdata = r_rdata;
   assign dfp_resp  = r_resp;
   assign busy      = r_busy;
   assign err       = r_err;

endmodule

// File: tb/tb_dfp_mem_responder.sv
// Directed bench for dfp_mem_responder: a requester model drives line transactions,
// read data is predicted from a line model and checked through a scoreboard queue.
module tb_dfp_mem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  dfp_addr = '0;
   logic         dfp_read = 1'b0;
   logic         dfp_write = 1'b0;
   logic [255:0] dfp_wdata = '0;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
   logic         busy;
   logic         err;

   int passed = 0;
   int total  = 0;
   int resp_cnt = 0;
   logic [255:0] model [int];
   logic [255:0] sb [$];

   dfp_mem_responder #(.DEPTH_LINES(DEPTH), .READ_LATENCY(LAT), .WRITE_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .dfp_addr(dfp_addr), .dfp_read(dfp_read),
      .dfp_write(dfp_write), .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata),
      .dfp_resp(dfp_resp), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (dfp_resp === 1'b1) resp_cnt++;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Full transaction: requester holds the request through the DRAIN cycle, then drops it.
   task automatic txn(input bit wr, input logic [31:0] a, input logic [255:0] d, input string tag);
      int n;
      int bcnt;
      int r0;
      bit got;
      int idx;
      logic [255:0] exp;
      idx = int'((a >> 5) & (DEPTH - 1));
      r0 = resp_cnt;
      @(posedge clk); #1;
      dfp_addr = a; dfp_wdata = d; dfp_write = wr; dfp_read = !wr;
      if (wr) model[idx] = d;
      else sb.push_back(model[idx]);
      n = 0; bcnt = 0; got = 0;
      while (!got && n < 20) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (busy) bcnt++;
         if (dfp_resp) got = 1;
      end
      check({tag, " resp_latency"}, 256'(n), 256'(LAT));
      if (got && !wr) begin
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            check({tag, " rdata"}, dfp_rdata, exp);
         end else begin
            check({tag, " scoreboard_empty"}, 256'(1), 256'(0));
         end
      end
      @(posedge clk); @(negedge clk);
      if (busy) bcnt++;
      check({tag, " resp_one_cycle"}, 256'(dfp_resp), 256'(0));
      @(posedge clk); #1;
      dfp_read = 1'b0; dfp_write = 1'b0;
      @(negedge clk);
      check({tag, " busy_after"}, 256'(busy), 256'(0));
      check({tag, " busy_cycles"}, 256'(bcnt), 256'(LAT + 1));
      check({tag, " resp_count"}, 256'(resp_cnt - r0), 256'(1));
   endtask

   initial begin
      int r0;
      // Reset state
      #12;
      check("rst dfp_resp", 256'(dfp_resp), 256'(0));
      check("rst dfp_rdata", dfp_rdata, 256'(0));
      check("rst busy", 256'(busy), 256'(0));
      check("rst err", 256'(err), 256'(0));
      rst_n = 1'b1;

      txn(1'b1, 32'h0000_0040, {8{32'hDEAD_BEEF}}, "wr40");
      txn(1'b0, 32'h0000_0040, 256'(0), "rd40");
      check("err after clean txns", 256'(err), 256'(0));

      // Simultaneous read and write in IDLE
      r0 = resp_cnt;
      @(posedge clk); #1;
      dfp_read = 1'b1; dfp_write = 1'b1; dfp_addr = 32'h40;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("both err", 256'(err), 256'(1));
      check("both busy", 256'(busy), 256'(0));
      check("both no resp", 256'(resp_cnt - r0), 256'(0));
      @(posedge clk); #1;
      dfp_read = 1'b0; dfp_write = 1'b0;
      txn(1'b0, 32'h0000_0040, 256'(0), "rd40 after err");
      check("err sticky", 256'(err), 256'(1));

      // Reset clears err; misaligned write then aliased reads
      #2 rst_n = 1'b0;
      #1 check("rst2 err", 256'(err), 256'(0));
      check("rst2 rdata", dfp_rdata, 256'(0));
      @(posedge clk); #2 rst_n = 1'b1;
      txn(1'b1, 32'h0000_2024, {8{32'h0BAD_A11E}}, "wr2024");
      check("misalign err", 256'(err), 256'(1));
      txn(1'b0, 32'h0000_2020, 256'(0), "rd2020");
      txn(1'b0, 32'h0000_0020, 256'(0), "rd0020 alias");

      // Reset in the middle of a write must not commit it
      txn(1'b1, 32'h0000_0080, {8{32'hCAFE_F00D}}, "wr80");
      r0 = resp_cnt;
      @(posedge clk); #1;
      dfp_addr = 32'h80; dfp_wdata = {8{32'h1111_1111}}; dfp_write = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort resp", 256'(dfp_resp), 256'(0));
      check("abort busy", 256'(busy), 256'(0));
      check("abort rdata", dfp_rdata, 256'(0));
      dfp_write = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("abort no resp", 256'(resp_cnt - r0), 256'(0));
      txn(1'b0, 32'h0000_0080, 256'(0), "rd80 after abort");
      check("scoreboard drained", 256'(sb.size()), 256'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
